roller_stream: RTL

Parametrised parallel-to-serial width converter for the conv datapath: accepts a NUM-element vector and emits it as ROLL_NUM-element beats over ceil(NUM/ROLL_NUM) cycles. It supports NUM not divisible by ROLL_NUM by zero-padding the final beat. A one-vector pending buffer sustains one output beat per cycle across consecutive vectors with no bubbles. It flags the last beat of each vector and reports the beat index.

---
 rtl/roller_stream.sv | 118 +++++++++++
 1 files changed

// File: rtl/roller_stream.sv
// Parallel-to-serial width converter: a NUM-element vector leaves as ROLL_NUM-element beats,
// with a one-vector pending slot so consecutive vectors stream without bubbles.
module roller_stream #(
  parameter  int DATA_WIDTH = 16,
  parameter  int NUM        = 8,
  parameter  int ROLL_NUM   = 2,
  localparam int CYCLES     = (NUM + ROLL_NUM - 1) / ROLL_NUM,
  localparam int BW         = (CYCLES > 1) ? $clog2(CYCLES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in [NUM-1:0],
  input  logic                  data_in_valid,
  output logic                  data_in_ready,
  output logic [DATA_WIDTH-1:0] data_out [ROLL_NUM-1:0],
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  data_out_last,
  output logic [BW-1:0]         data_out_beat
);

  logic [DATA_WIDTH-1:0] a_data_q [NUM-1:0];
  logic [DATA_WIDTH-1:0] a_data_d [NUM-1:0];
  logic [DATA_WIDTH-1:0] p_data_q [NUM-1:0];
  logic [DATA_WIDTH-1:0] p_data_d [NUM-1:0];
  logic                  a_valid_q, a_valid_d;
  logic                  p_valid_q, p_valid_d;
  logic [BW-1:0]         cnt_q, cnt_d;
  logic                  ready_q, ready_d;

  logic in_xfer;
  logic out_xfer;
  logic on_last;
  logic finish;

  assign on_last  = (cnt_q == BW'(CYCLES - 1));
  assign in_xfer  = data_in_valid && ready_q;
  assign out_xfer = a_valid_q && data_out_ready;
  assign finish   = out_xfer && on_last;

  assign data_in_ready  = ready_q;
  assign data_out_valid = a_valid_q;
  assign data_out_last  = a_valid_q && on_last;
  assign data_out_beat  = cnt_q;

  // Element indices past NUM pad the final beat with zeros.
  always_comb begin
    for (int j = 0; j < ROLL_NUM; j++) begin
      data_out[j] = '0;
      for (int i = 0; i < NUM; i++) begin
        if (i == int'(cnt_q) * ROLL_NUM + j) begin
          data_out[j] = a_data_q[i];
        end
      end
    end
  end

  always_comb begin
    a_data_d  = a_data_q;
    p_data_d  = p_data_q;
    a_valid_d = a_valid_q;
    p_valid_d = p_valid_q;
    cnt_d     = cnt_q;

    if (out_xfer && !on_last) begin
      cnt_d = cnt_q + 1'b1;
    end

    if (finish) begin
      cnt_d = '0;
      if (p_valid_q) begin
        a_data_d  = p_data_q;
        p_valid_d = 1'b0;
        if (in_xfer) begin
          p_data_d  = data_in;
          p_valid_d = 1'b1;
        end
      end else if (in_xfer) begin
        a_data_d = data_in;
      end else begin
        a_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      if (!a_valid_q) begin
        a_data_d  = data_in;
        a_valid_d = 1'b1;
        cnt_d     = '0;
      end else begin
        p_data_d  = data_in;
        p_valid_d = 1'b1;
      end
    end

    // Registered so the input side never sees data_out_ready combinationally.
    ready_d = !p_valid_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_valid_q <= 1'b0;
      p_valid_q <= 1'b0;
      cnt_q     <= '0;
      ready_q   <= 1'b0;
      for (int i = 0; i < NUM; i++) begin
        a_data_q[i] <= '0;
        p_data_q[i] <= '0;
      end
    end else begin
      a_valid_q <= a_valid_d;
      p_valid_q <= p_valid_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      a_data_q  <= a_data_d;
      p_data_q  <= p_data_d;
    end
  end

endmodule
